// File: rtl/bus_pkg.sv
// Shared bus definitions: transaction state encoding and default widths
// used by the master port, arbiter and slave port.
package bus_pkg;

    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 8;
    localparam int RD_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } bus_state_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/master_port_if.sv
// Serial bus seen by one master: arbitration pair plus LSB-first serial links.
// Handshake: request stays high until the transaction ends; grant low during a
// transfer aborts it; bus_out counts only when bus_out_valid=1 and bus_in only
// when bus_in_valid=1 (no back-pressure on either link).
interface master_port_if;

    logic request;
    logic slave_select;
    logic grant;
    logic bus_mode;
    logic bus_out;
    logic bus_out_valid;
    logic bus_in;
    logic bus_in_valid;

    modport master (
        output request, slave_select, bus_mode, bus_out, bus_out_valid,
        input  grant, bus_in, bus_in_valid
    );

    modport slave (
        input  request, slave_select, bus_mode, bus_out, bus_out_valid,
        output grant, bus_in, bus_in_valid
    );

endinterface

// File: rtl/master_port_serial_shifter.sv
// Shift register with bit counter shared by address, write-data and read-data
// phases: LSB leaves at bit 0, received bits enter at the MSB.
module serial_shifter #(
    parameter  int W    = 12,
    parameter  int IN_W = 8,
    localparam int CW   = $clog2(W) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [W-1:0]    load_data_i,
    input  logic            shift_i,
    input  logic            in_bit_i,
    input  logic [CW-1:0]   last_idx_i,
    output logic            out_bit_o,
    output logic [IN_W-1:0] rx_o,
    output logic            last_o
);

    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            sreg_d = {in_bit_i, sreg_q[W-1:1]};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_bit_o = sreg_q[0];
    // Word as it will stand once the current input bit is shifted in.
    assign rx_o      = {in_bit_i, sreg_q[W-1 -: IN_W-1]};
    assign last_o    = (cnt_q == last_idx_i);

endmodule

// File: rtl/master_port.sv
// Bus master: captures a local request, arbitrates, shifts the address and
// write data out LSB-first, or collects read data with a timeout.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rw,
    input  logic               slave_sel,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               done,
    output logic               err,
    output logic               busy,
    output bus_state_e         state_dbg_o,
    master_port_if.master      bus
);

    localparam int SW = max_w(ADDR_W, DATA_W);
    localparam int CW = $clog2(SW) + 1;
    localparam int TW = $clog2(RD_TIMEOUT) + 1;

    bus_state_e        state_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [TW-1:0]     tmo_q;
    logic              done_q, err_q, busy_q;
    logic              request_q, slave_select_q, bus_mode_q, bus_out_valid_q;

    logic              sh_load, sh_shift, sh_bit, sh_last;
    logic [SW-1:0]     sh_data;
    logic [CW-1:0]     sh_last_idx;
    logic [DATA_W-1:0] sh_rx;
    logic              xfer, tmo_last, finish;

    serial_shifter #(.W(SW), .IN_W(DATA_W)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (sh_load),
        .load_data_i (sh_data),
        .shift_i     (sh_shift),
        .in_bit_i    (bus.bus_in),
        .last_idx_i  (sh_last_idx),
        .out_bit_o   (sh_bit),
        .rx_o        (sh_rx),
        .last_o      (sh_last)
    );

    assign xfer     = state_q inside {ST_ADDR, ST_WDATA, ST_RWAIT, ST_RDATA};
    assign tmo_last = (tmo_q == TW'(RD_TIMEOUT - 1));
    assign finish   = bus.grant &&
                      (((state_q == ST_WDATA) && sh_last) ||
                       ((state_q == ST_RWAIT) && !bus.bus_in_valid && tmo_last) ||
                       ((state_q == ST_RDATA) && bus.bus_in_valid && sh_last));

    always_comb begin
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_data     = '0;
        sh_last_idx = CW'(DATA_W - 1);
        case (state_q)
            ST_REQ: begin
                sh_load = bus.grant;
                sh_data = SW'(addr_q);
            end
            ST_ADDR: begin
                sh_last_idx = CW'(ADDR_W - 1);
                if (bus.grant) begin
                    // Last address bit: preload write data, or clear for receive.
                    if (sh_last) begin
                        sh_load = 1'b1;
                        sh_data = rw_q ? SW'(wdata_q) : '0;
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            ST_WDATA:           sh_shift = bus.grant;
            ST_RWAIT, ST_RDATA: sh_shift = bus.grant & bus.bus_in_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            tmo_q           <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
            request_q       <= 1'b0;
            slave_select_q  <= 1'b0;
            bus_mode_q      <= 1'b0;
            bus_out_valid_q <= 1'b0;
        end else if (xfer && !bus.grant) begin
            // Lost the bus: fall back to arbitration, restart from address bit 0.
            state_q         <= ST_REQ;
            bus_mode_q      <= 1'b0;
            bus_out_valid_q <= 1'b0;
            tmo_q           <= '0;
        end else if (finish) begin
            state_q         <= ST_DONE;
            request_q       <= 1'b0;
            slave_select_q  <= 1'b0;
            bus_mode_q      <= 1'b0;
            bus_out_valid_q <= 1'b0;
            done_q          <= 1'b1;
            err_q           <= (state_q == ST_RWAIT);
            if (state_q == ST_RDATA) rdata_q <= sh_rx;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rw_q           <= rw;
                        addr_q         <= addr;
                        wdata_q        <= wdata;
                        busy_q         <= 1'b1;
                        request_q      <= 1'b1;
                        slave_select_q <= slave_sel;
                        state_q        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.grant) begin
                        state_q         <= ST_ADDR;
                        bus_mode_q      <= rw_q;
                        bus_out_valid_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sh_last) begin
                        bus_out_valid_q <= rw_q;
                        tmo_q           <= '0;
                        state_q         <= rw_q ? ST_WDATA : ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (bus.bus_in_valid) state_q <= ST_RDATA;
                    else                  tmo_q   <= tmo_q + TW'(1);
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rdata             = rdata_q;
    assign done              = done_q;
    assign err               = err_q;
    assign busy              = busy_q;
    assign state_dbg_o       = state_q;
    assign bus.request       = request_q;
    assign bus.slave_select  = slave_select_q;
    assign bus.bus_mode      = bus_mode_q;
    assign bus.bus_out_valid = bus_out_valid_q;
    assign bus.bus_out       = bus_out_valid_q & sh_bit;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: stimulus pushes expected {err, rdata, bit
// count, serial stream} entries; a negedge monitor pops one per done pulse.
module tb_master_port;
    import bus_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int EXP_W = 34;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          rw = 1'b0;
    logic          slave_sel = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          done, err, busy;
    bus_state_e    state_dbg;

    master_port_if bif();

    master_port #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(255)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rw          (rw),
        .slave_sel   (slave_sel),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .state_dbg_o (state_dbg),
        .bus         (bif.master)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int failed = 0;
    int done_count = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk_exp(input logic e, input logic [DW-1:0] rd,
                                                 input logic [4:0] nb, input logic [19:0] st);
        return {e, rd, nb, st};
    endfunction

    int               run_n = 0;
    logic [31:0]      run_bits = '0;
    logic             prev_v = 1'b0;
    logic [EXP_W-1:0] e_cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (bif.bus_out_valid) begin
                if (!prev_v) begin
                    run_n    = 0;
                    run_bits = '0;
                end
                if (run_n < 32) run_bits[run_n] = bif.bus_out;
                run_n++;
            end
            prev_v = bif.bus_out_valid;
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_done: got done=1 expected no pending transaction");
                end else begin
                    e_cur = exp_q.pop_front();
                    check("done_err",   err,      {31'h0, e_cur[33]});
                    check("done_rdata", rdata,    {24'h0, e_cur[32:25]});
                    check("bit_count",  run_n,    {27'h0, e_cur[24:20]});
                    check("bit_stream", run_bits, {12'h0, e_cur[19:0]});
                end
                check("busy_at_done", busy, 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic r, input logic s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        start = 1'b1; rw = r; slave_sel = s; addr = a; wdata = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_state(input bus_state_e s, input int budget, input string name);
        int n = 0;
        while (state_dbg != s && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (state_dbg != s) begin
            tests++;
            failed++;
            $display("FAIL %s: state 0x%0h after %0d cycles, wanted 0x%0h", name, state_dbg, n, s);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        int snap = done_count;
        while (done_count == snap && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_count == snap) begin
            tests++;
            failed++;
            $display("FAIL %s: got no done within %0d cycles expected one", name, budget);
        end
    endtask

    // Slave side of a read: idle for 'waits' RWAIT cycles, then LSB-first bits
    // with one invalid cycle inserted before bit 'gap_at'.
    task automatic drive_read(input logic [DW-1:0] data, input int waits, input int gap_at);
        wait_state(ST_RWAIT, 60, "reach_rwait");
        repeat (waits) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < DW; i++) begin
            if (i == gap_at) begin
                bif.bus_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bif.bus_in_valid = 1'b1;
            bif.bus_in       = data[i];
            @(posedge clk); #1;
        end
        bif.bus_in_valid = 1'b0;
        bif.bus_in       = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int cyc;
    int n;
    int k;
    int snap;

    initial begin
        bif.grant        = 1'b0;
        bif.bus_in       = 1'b0;
        bif.bus_in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bif.request, bif.slave_select, bif.bus_mode, bif.bus_out,
                                bif.bus_out_valid, done, err, busy}, 0);
        check("reset_rdata", rdata, 0);
        check("reset_state", state_dbg, ST_IDLE);
        reset     = 1'b0;
        bif.grant = 1'b1;

        // Write 0x5A3 / 0xC7 with grant held.
        exp_q.push_back(mk_exp(1'b0, 8'h00, 5'd20, {8'hC7, 12'h5A3}));
        issue(1'b1, 1'b1, 12'h5A3, 8'hC7);
        check("wr_busy", busy, 1);
        check("wr_request", bif.request, 1);
        check("wr_slave_select", bif.slave_select, 1);
        n = 0;
        while (!bif.bus_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wr_bus_mode", bif.bus_mode, 1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("wr_latency", cyc, 20);
        @(negedge clk);
        check("wr_busy_after", busy, 0);
        check("wr_request_after", bif.request, 0);

        // Read 0x010, slave returns 0x3C after 5 wait cycles with a gap.
        exp_q.push_back(mk_exp(1'b0, 8'h3C, 5'd12, {8'h00, 12'h010}));
        issue(1'b0, 1'b0, 12'h010, 8'h00);
        drive_read(8'h3C, 5, 4);
        wait_done(40, "rd_done");

        // Grant dropped after 4 address bits, regranted later.
        exp_q.push_back(mk_exp(1'b0, 8'h3C, 5'd20, {8'h5E, 12'h2B7}));
        snap = done_count;
        issue(1'b1, 1'b0, 12'h2B7, 8'h5E);
        n = 0;
        k = 0;
        while (k < 4 && n < 50) begin
            @(negedge clk);
            n++;
            if (bif.bus_out_valid) k++;
        end
        #1 bif.grant = 1'b0;
        @(posedge clk); #1;
        check("drop_to_req", state_dbg, ST_REQ);
        check("drop_valid_low", bif.bus_out_valid, 0);
        check("drop_request_held", bif.request, 1);
        repeat (2) @(posedge clk);
        #1 bif.grant = 1'b1;
        wait_done(60, "drop_done");
        repeat (3) @(posedge clk);
        check("drop_one_done", done_count, snap + 1);

        // Read with no data: timeout error, rdata keeps 0x3C.
        exp_q.push_back(mk_exp(1'b1, 8'h3C, 5'd12, {8'h00, 12'h0FF}));
        issue(1'b0, 1'b1, 12'h0FF, 8'h00);
        wait_state(ST_RWAIT, 60, "tmo_reach_rwait");
        cyc = 0;
        while (state_dbg == ST_RWAIT && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tmo_rwait_cycles", cyc, 255);
        wait_done(10, "tmo_done");

        // Asynchronous reset during WDATA, then an immediate new write.
        exp_q.push_back(mk_exp(1'b0, 8'h3C, 5'd20, {8'h96, 12'h3C5}));
        issue(1'b1, 1'b0, 12'h3C5, 8'h96);
        wait_state(ST_WDATA, 40, "rst_reach_wdata");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", {bif.request, bif.slave_select, bif.bus_mode, bif.bus_out,
                                    bif.bus_out_valid, done, err, busy}, 0);
        check("rst_async_rdata", rdata, 0);
        check("rst_async_state", state_dbg, ST_IDLE);
        exp_q.delete();
        snap = done_count;
        @(posedge clk); #1;
        exp_q.push_back(mk_exp(1'b0, 8'h00, 5'd20, {8'hA5, 12'h123}));
        reset = 1'b0;
        start = 1'b1; rw = 1'b1; slave_sel = 1'b1; addr = 12'h123; wdata = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        check("rst_start_first_edge", busy, 1);
        wait_done(60, "rst_new_done");
        repeat (3) @(posedge clk);
        check("rst_one_done", done_count, snap + 1);

        // Start pulsed while busy is ignored.
        exp_q.push_back(mk_exp(1'b0, 8'h00, 5'd20, {8'h81, 12'h7FE}));
        snap = done_count;
        issue(1'b1, 1'b1, 12'h7FE, 8'h81);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; rw = 1'b0; slave_sel = 1'b0; addr = 12'h001; wdata = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_sel_kept", bif.slave_select, 1);
        check("busy_start_mode_kept", bif.bus_mode, 1);
        wait_done(60, "busy_start_done");
        repeat (10) @(posedge clk);
        #1;
        check("busy_start_one_done", done_count, snap + 1);
        check("busy_start_idle", busy, 0);

        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
